seg_display_arbiter: RTL and testbench

Shares the two-digit seven-segment display driver between several requesters (status counters, error codes, debug taps). Each requester raises a level request with its 8-bit value. A round-robin scheduler with a minimum dwell time picks one owner and forwards that owner's value to the display driver's `value` input. The block sits between the requesting logic and the seven-segment driver and is the only writer of that driver's value.

---
 rtl/seg_display_arbiter.sv | 160 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin owner selection for the shared two-digit seven-segment driver,
// with a minimum dwell time under contention. The winning requester's 8-bit
// value is registered onto value_out.
// Optional feature macro: SEG_ARB_LOCK_EN (adds a 'lock' input that freezes
// dwell-based rotation while the owner keeps requesting).
//
// state | meaning
// IDLE  | nobody owns the display, grant=0, blank=1, value_out held
// SHOW  | owner_q drives value_out every cycle, cnt_q holds remaining dwell

module seg_display_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWELL   = 50_000_000,
  parameter int DWELL_W = 26
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SEG_ARB_LOCK_EN
  input  logic                lock,
`endif
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   value_in,
  output logic [7:0]          value_out,
  output logic                blank,
  output logic [NREQ-1:0]     grant,
  output logic                switch_stb
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [DWELL_W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic [7:0]            value_out_q, value_out_d;
  logic                  blank_q, blank_d;
  logic                  switch_stb_q, switch_stb_d;

  logic [7:0]            slice [NREQ];
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic                  lock_hold;
  logic                  take;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = value_in[8*gi +: 8];
    end
  endgenerate

`ifdef SEG_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Round-robin search starting one past the last owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and output computation for the IDLE/SHOW scheduler.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    value_out_d  = value_out_q;
    blank_d      = blank_q;
    switch_stb_d = 1'b0;
    take         = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        blank_d = 1'b1;
        if (pick_found) take = 1'b1;
      end
      S_SHOW: begin
        value_out_d = slice[owner_q];
        if (!req[owner_q]) begin
          // Owner released: hand over at once, or fall back to IDLE with
          // value_out left at its last value.
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d     = S_IDLE;
            grant_d     = '0;
            blank_d     = 1'b1;
            value_out_d = value_out_q;
          end
        end else if ((cnt_q == '0) && ((req & ~grant_q) != '0) && !lock_hold) begin
          take = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take) begin
      state_d           = S_SHOW;
      grant_d           = '0;
      grant_d[pick_idx] = 1'b1;
      owner_d           = pick_idx;
      last_d            = pick_idx;
      value_out_d       = slice[pick_idx];
      blank_d           = 1'b0;
      cnt_d             = DWELL_W'(DWELL - 1);
      switch_stb_d      = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_q       <= IDX_W'(NREQ - 1);
      cnt_q        <= '0;
      grant_q      <= '0;
      value_out_q  <= 8'h00;
      blank_q      <= 1'b1;
      switch_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      value_out_q  <= value_out_d;
      blank_q      <= blank_d;
      switch_stb_q <= switch_stb_d;
    end
  end

  assign grant      = grant_q;
  assign value_out  = value_out_q;
  assign blank      = blank_q;
  assign switch_stb = switch_stb_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed sequences with literal expectations
// followed by randomized traffic checked every cycle against a reference model.
module tb_seg_display_arbiter;

  localparam int NREQ    = 4;
  localparam int DWELL   = 4;
  localparam int DWELL_W = 3;
`ifdef SEG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                lock = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [8*NREQ-1:0]   value_in = '0;
  logic [7:0]          value_out;
  logic                blank;
  logic [NREQ-1:0]     grant;
  logic                switch_stb;

  int errors = 0;
  int checks = 0;

  seg_display_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SEG_ARB_LOCK_EN
    .lock       (lock),
`endif
    .req        (req),
    .value_in   (value_in),
    .value_out  (value_out),
    .blank      (blank),
    .grant      (grant),
    .switch_stb (switch_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_owner = -1;
  int          m_last  = NREQ - 1;
  int          m_age   = 0;       // cycles the current owner has held the grant
  logic [7:0]  m_vo    = 8'h00;
  bit          m_vo_known = 1'b0;
  bit          m_stb   = 1'b0;
  bit          m_valid = 1'b0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int from_last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (from_last + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] slot(input int i);
    return value_in[8*i +: 8];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic m_take(input int w);
    m_owner    = w;
    m_last     = w;
    m_age      = 1;
    m_vo       = slot(w);
    m_vo_known = 1'b1;
    m_stb      = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_owner = -1; m_last = NREQ - 1; m_age = 0;
        m_vo = 8'h00; m_vo_known = 1'b1; m_stb = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
        int w;
        w = rr_pick(req, m_last);
        m_stb = 1'b0;
        if (m_owner < 0) begin
          if (w >= 0) m_take(w);
        end else if (!req[m_owner]) begin
          if (w >= 0) m_take(w);
          else begin
            m_owner = -1;
            m_vo_known = 1'b0;
          end
        end else if (m_age >= DWELL && (req & ~onehot(m_owner)) != '0
                     && !(LOCK_EN && lock)) begin
          m_take(w);
        end else begin
          m_age++;
          m_vo = slot(m_owner);
        end
      end
      #1;
      if (m_valid) begin
        chk("model_grant", 32'(grant), 32'(onehot(m_owner)));
        chk("model_blank", 32'(blank), 32'(m_owner < 0));
        chk("model_stb", 32'(switch_stb), 32'(m_stb));
        if (m_vo_known) chk("model_value", 32'(value_out), 32'(m_vo));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    lock  = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nstb;
    value_in = {8'hB3, 8'h22, 8'hA1, 8'h11};

    // Reset with all requesters active.
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_blank", 32'(blank), 32'h1);
    chk("rst_value", 32'(value_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_stb", 32'(switch_stb), 32'h1);
    chk("first_value", 32'(value_out), 32'h11);
    step();
    chk("stb_one_cycle", 32'(switch_stb), 32'h0);

    // Contention between requesters 1 and 3.
    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 12; k++) begin
      step();
      if (((k / 4) % 2) == 0) begin
        chk("cont_grant", 32'(grant), 32'h2);
        chk("cont_value", 32'(value_out), 32'hA1);
      end else begin
        chk("cont_grant", 32'(grant), 32'h8);
        chk("cont_value", 32'(value_out), 32'hB3);
      end
      if ((k % 4) == 0) chk("cont_stb", 32'(switch_stb), 32'h1);
    end

    // Early release by owner 2 while requester 0 waits.
    do_reset();
    req = 4'b0100;
    step();
    chk("early_grant2", 32'(grant), 32'h4);
    @(negedge clk);
    req = 4'b0001;
    step();
    chk("early_grant0", 32'(grant), 32'h1);
    chk("early_stb", 32'(switch_stb), 32'h1);
    @(negedge clk);
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reload_hold", 32'(grant), 32'h1);
    end
    step();
    chk("reload_rotate", 32'(grant), 32'h4);

    // Sole owner, then a late competitor.
    do_reset();
    req  = 4'b0100;
    nstb = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("sole_grant", 32'(grant), 32'h4);
      nstb += int'(switch_stb);
    end
    chk("sole_stb_count", 32'(nstb), 32'd1);
    @(negedge clk);
    req = 4'b0110;
    step();
    chk("late_comp_grant", 32'(grant), 32'h2);

    // Reset in the middle of a dwell.
    do_reset();
    req = 4'b1010;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_blank", 32'(blank), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    step();
    chk("post_rst_pick0", 32'(grant), 32'h1);

`ifdef SEG_ARB_LOCK_EN
    // Lock freezes rotation; dropping it rotates on the next edge.
    do_reset();
    lock = 1'b1;
    req  = 4'b0011;
    for (int k = 0; k < 50; k++) begin
      step();
      chk("lock_hold", 32'(grant), 32'h1);
    end
    @(negedge clk);
    lock = 1'b0;
    step();
    chk("lock_release", 32'(grant), 32'h2);
`endif

    // Randomized traffic; the model process checks every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 2) == 0) value_in = $urandom;
      if (LOCK_EN && $urandom_range(0, 31) == 0) lock = ~lock;
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
